systolic_skew_feeder: RTL and testbench

// - Upstream stage of SystolicArray: takes one K-slice per handshake (column k of A, row k of B)
//   and drives the array's row[]/column[] edge ports with the diagonal skew the array needs.
// - Sequences one tile: pulses clear, feeds k_len slices, drains skew, waits for array ready, pulses done.
// - Sits between the operand buffers / DMA and SystolicArray; all data is `SINGLE (fp32 bits).

---
 rtl/systolic_skew_feeder_pkg.sv | 20 ++
 rtl/systolic_skew_feeder_delay.sv | 27 ++
 rtl/systolic_skew_feeder.sv | 93 +++++++++
 tb/tb_systolic_skew_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_skew_feeder_pkg: shared operand width, array size, lane scalar type and feeder FSM states
//   single_t       : fp32 bit pattern carried through unchanged
//   scalar_t       : one edge-port lane, {data, valid}
//   feeder_state_e : tile sequencing states
package systolic_skew_feeder_pkg;
    localparam int SINGLE_W      = 32;
    localparam int SYS_ARRAY_LEN = 4;
    typedef logic [SINGLE_W-1:0] single_t;
    typedef struct packed {
        single_t data;
        logic    valid;
    } scalar_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_WAIT
    } feeder_state_e;
endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// skew_delay_line: DEPTH-stage shift register of lane scalars; shifts every cycle
//   clk, rst_n : clock, asynchronous active-low reset (clears every stage)
//   d          : lane scalar entering stage 0
//   q          : lane scalar leaving the last stage
module skew_delay_line
    import systolic_skew_feeder_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  scalar_t d,
    output scalar_t q
);
    scalar_t [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: sequences one systolic tile and feeds K-slices onto the array edges with diagonal skew
//   clk, rst_n      : clock, asynchronous active-low reset (aborts a tile, no done)
//   start, k_len    : begin a tile of k_len slices; sampled in IDLE only
//   in_valid/ready  : slice handshake; a_col = A[.][k], b_row = B[k][.]
//   row, column     : skewed {data, valid} lanes to the array edges
//   clear           : one-cycle accumulator clear at tile start
//   array_ready     : array has finished accumulating
//   busy, done      : tile in progress; one-cycle completion pulse
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int N   = SYS_ARRAY_LEN,
    parameter int K_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  single_t [N-1:0]      a_col,
    input  single_t [N-1:0]      b_row,
    output scalar_t [N-1:0]      row,
    output scalar_t [N-1:0]      column,
    output logic                 clear,
    input  logic                 array_ready,
    output logic                 busy,
    output logic                 done
);
    feeder_state_e     state, state_nx;
    logic [K_W-1:0]    cnt, k_last;
    logic              xfer, zero_done;
    scalar_t [N-1:0]   row_in, col_in;

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // cnt counts transfers in FEED and bubble cycles in DRAIN; it restarts on every state change
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = (start && k_len != '0) ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_nx = ST_FEED;
            ST_FEED:  state_nx = (xfer && cnt == k_last) ? ST_DRAIN : ST_FEED;
            ST_DRAIN: state_nx = (cnt == K_W'(N - 2)) ? ST_WAIT : ST_DRAIN;
            ST_WAIT:  state_nx = array_ready ? ST_IDLE : ST_WAIT;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == ST_FEED;
        busy     = state != ST_IDLE;
        done     = (state == ST_WAIT && array_ready) || zero_done;
    end

    // a zero-length tile never leaves IDLE; its done comes from a one-cycle flag instead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            k_last    <= '0;
            clear     <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            cnt       <= (state_nx != state) ? '0 : (xfer || state == ST_DRAIN) ? cnt + 1'b1 : cnt;
            k_last    <= (state == ST_IDLE && start) ? k_len - 1'b1 : k_last;
            clear     <= state == ST_IDLE && start && k_len != '0;
            zero_done <= state == ST_IDLE && start && k_len == '0;
        end
    end

    // non-transfer cycles push zero bubbles so invalid lanes always read {0, 0}
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign row_in[i] = xfer ? {a_col[i], 1'b1} : '0;
        assign col_in[i] = xfer ? {b_row[i], 1'b1} : '0;
        skew_delay_line #(.DEPTH(i + 1)) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (row_in[i]),
            .q     (row[i])
        );
        skew_delay_line #(.DEPTH(i + 1)) u_col (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (col_in[i]),
            .q     (column[i])
        );
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: randomized tile sequences checked against a transfer-history model of the skewed edges
module tb_systolic_skew_feeder;
    import systolic_skew_feeder_pkg::*;
    localparam int N   = 4;
    localparam int K_W = 16;
    localparam int HN  = 4096;

    logic            clk = 0, rst_n = 1, start = 0, in_valid = 0, array_ready = 0;
    logic [K_W-1:0]  k_len = '0;
    single_t [N-1:0] a_col = '0, b_row = '0;
    scalar_t [N-1:0] row, column;
    logic            in_ready, clear, busy, done;

    int      passes = 0, total = 0, edge_n = 16;
    logic    hv [HN];
    single_t ha [HN][N];
    single_t hb [HN][N];

    systolic_skew_feeder #(.N(N), .K_W(K_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k_len       (k_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_col       (a_col),
        .b_row       (b_row),
        .row         (row),
        .column      (column),
        .clear       (clear),
        .array_ready (array_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // lane i, observed after edge e, carries whatever was transferred at edge e-i
    task automatic cycle(input logic er, input logic eb, input logic ec, input logic ed);
        int h, w;
        logic [32:0] ex;
        @(negedge clk);
        check("in_ready", in_ready, er);
        check("busy", busy, eb);
        check("clear", clear, ec);
        check("done", done, ed);
        for (int i = 0; i < N; i++) begin
            h  = (edge_n - i) % HN;
            ex = hv[h] ? {ha[h][i], 1'b1} : 33'd0;
            check($sformatf("row%0d", i), row[i], ex);
            ex = hv[h] ? {hb[h][i], 1'b1} : 33'd0;
            check($sformatf("col%0d", i), column[i], ex);
        end
        w = (edge_n + 1) % HN;
        hv[w] = in_valid && er;
        for (int i = 0; i < N; i++) begin
            ha[w][i] = a_col[i];
            hb[w][i] = b_row[i];
        end
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            a_col[i] = $urandom;
            b_row[i] = $urandom;
        end
    endtask

    task automatic run_tile(input int k, input int gap, input bit alt, input bit hold, input int waits,
                            input bit fixed, input single_t [N-1:0] fa, input single_t [N-1:0] fb);
        int rem = k, n = 0;
        start = 1;
        k_len = K_W'(k);
        cycle(0, 0, 0, 0);
        start = hold;
        if (hold) k_len = K_W'($urandom);
        cycle(0, 1, 1, 0);
        while (rem > 0) begin
            in_valid = alt ? (n % 2 == 0) : ($urandom_range(99) >= gap);
            n++;
            if (fixed) begin
                a_col = fa;
                b_row = fb;
            end else rand_data();
            if (hold) k_len = K_W'($urandom);
            cycle(1, 1, 0, 0);
            if (in_valid) rem--;
        end
        for (int d = 0; d < N - 1; d++) begin
            in_valid = 1'($urandom);
            rand_data();
            cycle(0, 1, 0, 0);
        end
        array_ready = 0;
        for (int w = 0; w < waits; w++) cycle(0, 1, 0, 0);
        array_ready = 1;
        cycle(0, 1, 0, 1);
        array_ready = 1'($urandom);
        start = 0;
        in_valid = 0;
    endtask

    task automatic zero_tile();
        start = 1;
        k_len = '0;
        cycle(0, 0, 0, 0);
        start = 0;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        single_t [N-1:0] fa, fb;
        for (int h = 0; h < HN; h++) hv[h] = 0;
        #1 rst_n = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_clear", clear, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        for (int i = 0; i < N; i++) begin
            check("rst_row", row[i], 0);
            check("rst_col", column[i], 0);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0);

        fa = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000};
        fb = {4{32'h40a00000}};
        run_tile(1, 0, 0, 0, 2, 1, fa, fb);
        fa = {4{32'h40400000}};
        run_tile(3, 0, 0, 0, 1, 1, fa, fb);
        run_tile(3, 0, 1, 0, 0, 1, fa, fb);
        zero_tile();
        run_tile(4, 30, 0, 1, 3, 0, fa, fb);

        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(4) == 0) zero_tile();
            run_tile($urandom_range(1, 9), $urandom_range(0, 60), 0, 1'($urandom),
                     $urandom_range(0, 3), 0, fa, fb);
        end

        start = 1;
        k_len = 16'd6;
        cycle(0, 0, 0, 0);
        start = 0;
        cycle(0, 1, 1, 0);
        in_valid = 1;
        rand_data();
        cycle(1, 1, 0, 0);
        rand_data();
        cycle(1, 1, 0, 0);
        #2 rst_n = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_clear", clear, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < N; i++) begin
            check("abort_row", row[i], 0);
            check("abort_col", column[i], 0);
        end
        for (int h = 0; h < HN; h++) hv[h] = 0;
        in_valid = 0;
        array_ready = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) cycle(0, 0, 0, 0);
        run_tile(2, 20, 0, 0, 1, 0, fa, fb);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
